// File: rtl/pwm_duty_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_duty_gen_if
// Description : Sel command / Y feedback link between fsm_ctrl and
//               pwm_duty_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_gen_if;
   logic [1:0] Sel;   // 00 hold, 01 increment, 10 decrement, 11 hold
   logic [6:0] Y;     // current duty, 0..100

   // fsm_ctrl side: issues commands and watches the duty value for limits
   modport master (output Sel, input Y);
   // duty generator side: consumes commands and reports the duty value
   modport slave (input Sel, output Y);
endinterface
`default_nettype wire

// File: rtl/pwm_duty_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_duty_gen
// Description : Saturating duty register driven by Sel commands, plus a
//               100-step PWM generator that runs from a shadow copy of the
//               duty. The shadow is refreshed only at the period wrap, so the
//               waveform never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_gen #(
   parameter int PRESC_DIV = 500,  // clk cycles per PWM tick, >= 1
   parameter int STEP      = 1,    // duty change per command, 1..100
   parameter int DUTY_RST  = 0     // duty after reset, 0..100
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         ena_i,
   pwm_duty_gen_if.slave     sel_if,
   output logic              pwm_out_o,
   output logic              period_end_o
);

   localparam int            PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
   localparam logic [7:0]    STEP8      = 8'(STEP);
   localparam logic [7:0]    DUTY_MAX8  = 8'd100;
   localparam logic [6:0]    DUTY_MAX   = 7'd100;
   localparam logic [6:0]    DUTY_INIT  = 7'(DUTY_RST);
   localparam logic [6:0]    PHASE_LAST = 7'd99;

   logic [6:0]    y_q, y_d;
   logic [6:0]    shadow_q, shadow_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    phase_q, phase_d;
   logic          pwm_q, pwm_d;
   logic          pe_q, pe_d;

   logic [7:0]    y_sum;
   logic          tick;
   logic          wrap;

   // Duty register next value; 8-bit sum so the saturation test sees overflow.
   always_comb begin
      y_sum = {1'b0, y_q} + STEP8;
      y_d   = y_q;
      case (sel_if.Sel)
         2'b01:   y_d = (y_sum > DUTY_MAX8) ? DUTY_MAX : y_sum[6:0];
         2'b10:   y_d = ({1'b0, y_q} < STEP8) ? 7'd0 : (y_q - STEP8[6:0]);
         default: y_d = y_q;
      endcase
   end

   // Prescaler, phase counter, shadow refresh and registered PWM compare.
   always_comb begin
      tick     = (presc_q == PRESC_LAST);
      wrap     = tick && (phase_q == PHASE_LAST);
      presc_d  = tick ? '0 : (presc_q + PW'(1));
      phase_d  = phase_q;
      if (tick) begin
         phase_d = wrap ? 7'd0 : (phase_q + 7'd1);
      end
      // Shadow takes the pre-update Y, so a command on the wrap edge lands
      // one period later.
      shadow_d = wrap ? y_q : shadow_q;
      pwm_d    = (phase_q < shadow_q);
      pe_d     = wrap;
   end

   // State update; reset wins over ena, ena=0 freezes all but period_end.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q      <= DUTY_INIT;
         shadow_q <= DUTY_INIT;
         presc_q  <= '0;
         phase_q  <= 7'd0;
         pwm_q    <= 1'b0;
         pe_q     <= 1'b0;
      end else if (ena_i) begin
         y_q      <= y_d;
         shadow_q <= shadow_d;
         presc_q  <= presc_d;
         phase_q  <= phase_d;
         pwm_q    <= pwm_d;
         pe_q     <= pe_d;
      end else begin
         pe_q     <= 1'b0;
      end
   end

   assign sel_if.Y     = y_q;
   assign pwm_out_o    = pwm_q;
   assign period_end_o = pe_q;

endmodule
`default_nettype wire
